// File: rtl/ps2_kb_rx_pkg.sv
// Shared PS/2 receive definitions: FSM state encodings, frame geometry and timeout default.
package ps2_kb_rx_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  // start + 8 data + parity + stop
  localparam int FRAME_BITS = 11;

  localparam int DEFAULT_TIMEOUT_US = 200;

  // PS/2 uses odd parity: data plus parity bit must hold an odd number of ones.
  function automatic logic parityOk(input logic [7:0] dataByte, input logic parityBit);
    return ^{dataByte, parityBit};
  endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// First-word-fall-through scancode FIFO; head is visible on rdData whenever notEmpty is high.
module ps2_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wrData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdData,
  output logic                     notEmpty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rdPtr;
  logic [AW-1:0]    wrPtr;
  logic             full;
  logic             doPop;
  logic             doPush;

  assign full     = (count == (AW+1)'(DEPTH));
  assign notEmpty = (count != '0);
  assign doPop    = pop && notEmpty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign doPush   = push && (!full || doPop);
  assign overflow = push && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      if (doPush && !doPop)      count <= count + 1'b1;
      else if (doPop && !doPush) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= wrData;
  end

  assign rdData = notEmpty ? mem[rdPtr] : '0;

endmodule

// File: rtl/ps2_kb_rx.sv
// PS/2 keyboard receiver: synchronizes and de-glitches the PS/2 lines, deframes
// 11-bit frames with odd-parity and stop checks, and queues good scancodes.
module ps2_kb_rx
  import ps2_kb_rx_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int FIFO_DEPTH = 8,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_US = DEFAULT_TIMEOUT_US
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          kb_clk_i,
  input  logic                          kb_dat_i,
  input  logic                          rd_i,
  input  logic                          err_clr_i,
  output logic [7:0]                    data_o,
  output logic                          valid_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          parity_err_o,
  output logic                          frame_err_o,
  output logic                          overflow_o
);

  localparam int TIMEOUT_CYC = CLK_FREQ / 1000000 * TIMEOUT_US;
  localparam int TW          = $clog2(TIMEOUT_CYC + 1);
  localparam int FW          = $clog2(FILTER_LEN + 1);

  logic [1:0]    clkSync;
  logic [1:0]    datSync;
  logic          filtClk;
  logic          filtPrev;
  logic [FW-1:0] filtCnt;
  logic          fall;
  logic          datBit;

  logic [1:0]    state;
  logic [2:0]    bitCnt;
  logic [7:0]    shiftReg;
  logic          parityBit;
  logic [TW-1:0] tmoCnt;

  logic          timeout;
  logic          stopFall;
  logic          push;
  logic          parityErrEv;
  logic          frameErrEv;
  logic          fifoOvf;

  // Stage: 2-FF synchronizers, reset to the idle-high line level
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clkSync <= 2'b11;
      datSync <= 2'b11;
    end else begin
      clkSync <= {clkSync[0], kb_clk_i};
      datSync <= {datSync[0], kb_dat_i};
    end
  end

  // Stage: glitch filter, flips only after FILTER_LEN consecutive opposite samples
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      filtClk  <= 1'b1;
      filtPrev <= 1'b1;
      filtCnt  <= '0;
    end else begin
      filtPrev <= filtClk;
      if (clkSync[1] == filtClk) begin
        filtCnt <= '0;
      end else if (filtCnt == FW'(FILTER_LEN - 1)) begin
        filtClk <= clkSync[1];
        filtCnt <= '0;
      end else begin
        filtCnt <= filtCnt + 1'b1;
      end
    end
  end

  assign fall   = filtPrev && !filtClk;
  assign datBit = datSync[1];

  assign timeout     = (state != ST_IDLE) && !fall && (tmoCnt == TW'(TIMEOUT_CYC - 1));
  assign stopFall    = fall && (state == ST_STOP);
  assign push        = stopFall && datBit && parityOk(shiftReg, parityBit);
  assign parityErrEv = stopFall && datBit && !parityOk(shiftReg, parityBit);
  assign frameErrEv  = (stopFall && !datBit) || timeout;

  // Stage: frame FSM and inactivity timeout
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      bitCnt    <= '0;
      shiftReg  <= '0;
      parityBit <= 1'b0;
      tmoCnt    <= '0;
    end else begin
      if (state == ST_IDLE || fall) tmoCnt <= '0;
      else                          tmoCnt <= tmoCnt + 1'b1;

      if (timeout) begin
        state  <= ST_IDLE;
        bitCnt <= '0;
      end else if (fall) begin
        case (state)
          ST_IDLE: begin
            if (!datBit) begin
              state  <= ST_DATA;
              bitCnt <= '0;
            end
          end
          ST_DATA: begin
            shiftReg <= {datBit, shiftReg[7:1]};
            bitCnt   <= bitCnt + 1'b1;
            if (bitCnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            parityBit <= datBit;
            state     <= ST_STOP;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Stage: sticky error flags; a fresh event outranks a simultaneous clear
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overflow_o   <= 1'b0;
    end else begin
      if (parityErrEv)    parity_err_o <= 1'b1;
      else if (err_clr_i) parity_err_o <= 1'b0;
      if (frameErrEv)     frame_err_o  <= 1'b1;
      else if (err_clr_i) frame_err_o  <= 1'b0;
      if (fifoOvf)        overflow_o   <= 1'b1;
      else if (err_clr_i) overflow_o   <= 1'b0;
    end
  end

  ps2_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) uFifo (
    .clk      (clk_i),
    .rst      (rst_i),
    .push     (push),
    .wrData   (shiftReg),
    .pop      (rd_i),
    .rdData   (data_o),
    .notEmpty (valid_o),
    .count    (count_o),
    .overflow (fifoOvf)
  );

endmodule

// File: tb/tb_ps2_kb_rx.sv
// Randomized self-checking bench for ps2_kb_rx against a queue-based frame model.
`timescale 1ns/1ps
module tb_ps2_kb_rx;

  localparam int DEPTH = 8;

  logic       clk_i     = 1'b0;
  logic       rst_i     = 1'b1;
  logic       kb_clk_i  = 1'b1;
  logic       kb_dat_i  = 1'b1;
  logic       rd_i      = 1'b0;
  logic       err_clr_i = 1'b0;
  logic [7:0] data_o;
  logic       valid_o;
  logic [3:0] count_o;
  logic       parity_err_o;
  logic       frame_err_o;
  logic       overflow_o;

  int checks = 0;
  int errors = 0;

  byte unsigned q[$];
  logic expPar = 1'b0;
  logic expFrm = 1'b0;
  logic expOvf = 1'b0;

  // 1 MHz system clock keeps a 12.5 kHz PS/2 bit at 80 cycles; timeout is 200 cycles.
  always #500 clk_i = ~clk_i;

  ps2_kb_rx #(
    .CLK_FREQ   (1000000),
    .FIFO_DEPTH (DEPTH),
    .FILTER_LEN (8),
    .TIMEOUT_US (200)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .kb_clk_i     (kb_clk_i),
    .kb_dat_i     (kb_dat_i),
    .rd_i         (rd_i),
    .err_clr_i    (err_clr_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .count_o      (count_o),
    .parity_err_o (parity_err_o),
    .frame_err_o  (frame_err_o),
    .overflow_o   (overflow_o)
  );

  task automatic waitCyc(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // Frame layout on the wire, LSB first: start 0, data[7:0], odd parity, stop 1.
  function automatic logic [10:0] mkFrame(input logic [7:0] d, input logic flip);
    logic par;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += d[i];
    par = ((ones % 2) == 0) ? 1'b1 : 1'b0;
    return {1'b1, par ^ flip, d, 1'b0};
  endfunction

  task automatic sendBits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      kb_dat_i = bits[i];
      waitCyc(20);
      kb_clk_i = 1'b0;
      waitCyc(40);
      kb_clk_i = 1'b1;
      waitCyc(20);
    end
    kb_dat_i = 1'b1;
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic flip);
    sendBits(mkFrame(d, flip), 11);
    if (flip) expPar = 1'b1;
    else if (q.size() == DEPTH) expOvf = 1'b1;
    else q.push_back(d);
    waitCyc(40);
  endtask

  task automatic popOne();
    rd_i = 1'b1;
    waitCyc(1);
    rd_i = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
    waitCyc(1);
  endtask

  task automatic clearErr();
    err_clr_i = 1'b1;
    waitCyc(1);
    err_clr_i = 1'b0;
    expPar = 1'b0;
    expFrm = 1'b0;
    expOvf = 1'b0;
    waitCyc(1);
  endtask

  function automatic logic [7:0] headExp();
    return (q.size() > 0) ? q[0] : 8'h00;
  endfunction

  task automatic test_reset();
    rst_i = 1'b1;
    waitCyc(4);
    rst_i = 1'b0;
    waitCyc(4);
    checks++;
    if ({valid_o, count_o, data_o} !== 13'h0) begin
      errors++;
      $display("FAIL reset_fifo got v=%0b c=%0d d=%02h expected 0 0 00", valid_o, count_o, data_o);
    end
    checks++;
    if ({parity_err_o, frame_err_o, overflow_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got %b expected 000", {parity_err_o, frame_err_o, overflow_o});
    end
  endtask

  task automatic test_two_frames();
    sendFrame(8'h1C, 1'b0);
    sendFrame(8'hF0, 1'b0);
    checks++;
    if (count_o !== 4'(q.size()) || count_o !== 4'd2) begin
      errors++;
      $display("FAIL two_count got %0d expected 2", count_o);
    end
    checks++;
    if (data_o !== 8'h1C || valid_o !== 1'b1) begin
      errors++;
      $display("FAIL two_head got %02h v=%0b expected 1c v=1", data_o, valid_o);
    end
    popOne();
    checks++;
    if (data_o !== headExp() || data_o !== 8'hF0) begin
      errors++;
      $display("FAIL two_second got %02h expected f0", data_o);
    end
    checks++;
    if ({parity_err_o, frame_err_o, overflow_o} !== 3'b000) begin
      errors++;
      $display("FAIL two_flags got %b expected 000", {parity_err_o, frame_err_o, overflow_o});
    end
    popOne();
    checks++;
    if (valid_o !== 1'b0 || count_o !== 4'd0) begin
      errors++;
      $display("FAIL two_drain got v=%0b c=%0d expected 0 0", valid_o, count_o);
    end
  endtask

  task automatic test_parity_err();
    sendFrame(8'h1C, 1'b1);
    checks++;
    if (parity_err_o !== expPar || parity_err_o !== 1'b1) begin
      errors++;
      $display("FAIL par_flag got %0b expected 1", parity_err_o);
    end
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL par_discard got valid=%0b expected 0", valid_o);
    end
    clearErr();
    checks++;
    if (parity_err_o !== 1'b0) begin
      errors++;
      $display("FAIL par_clear got %0b expected 0", parity_err_o);
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 9; i++) sendFrame(8'(i), 1'b0);
    checks++;
    if (count_o !== 4'(q.size()) || count_o !== 4'd8) begin
      errors++;
      $display("FAIL ovf_count got %0d expected 8", count_o);
    end
    checks++;
    if (overflow_o !== expOvf || overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL ovf_flag got %0b expected 1", overflow_o);
    end
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (data_o !== headExp() || data_o !== 8'(i)) begin
        errors++;
        $display("FAIL ovf_pop%0d got %02h expected %02h", i, data_o, 8'(i));
      end
      popOne();
    end
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL ovf_empty got valid=%0b expected 0", valid_o);
    end
    clearErr();
  endtask

  task automatic test_timeout();
    sendBits(mkFrame(8'hA5, 1'b0), 5);
    expFrm = 1'b1;
    waitCyc(250);
    checks++;
    if (frame_err_o !== expFrm) begin
      errors++;
      $display("FAIL tmo_flag got %0b expected 1", frame_err_o);
    end
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL tmo_discard got valid=%0b expected 0", valid_o);
    end
    clearErr();
    sendFrame(8'h5A, 1'b0);
    checks++;
    if (data_o !== 8'h5A || count_o !== 4'd1 || frame_err_o !== 1'b0) begin
      errors++;
      $display("FAIL tmo_next got d=%02h c=%0d fe=%0b expected 5a 1 0", data_o, count_o, frame_err_o);
    end
    popOne();
  endtask

  task automatic test_glitch();
    kb_dat_i = 1'b0;
    waitCyc(2);
    kb_clk_i = 1'b0;
    waitCyc(3);
    kb_clk_i = 1'b1;
    waitCyc(2);
    kb_dat_i = 1'b1;
    waitCyc(30);
    checks++;
    if (valid_o !== 1'b0 || {parity_err_o, frame_err_o, overflow_o} !== 3'b000) begin
      errors++;
      $display("FAIL glitch_quiet got v=%0b flags=%b expected 0 000", valid_o,
               {parity_err_o, frame_err_o, overflow_o});
    end
    sendFrame(8'h33, 1'b0);
    checks++;
    if (data_o !== 8'h33 || count_o !== 4'd1) begin
      errors++;
      $display("FAIL glitch_next got d=%02h c=%0d expected 33 1", data_o, count_o);
    end
    popOne();
  endtask

  task automatic test_reset_midframe();
    sendFrame(8'h77, 1'b0);
    sendFrame(8'h12, 1'b1);
    sendBits(mkFrame(8'hC3, 1'b0), 5);
    rst_i = 1'b1;
    waitCyc(2);
    q.delete();
    expPar = 1'b0;
    expFrm = 1'b0;
    expOvf = 1'b0;
    checks++;
    if ({valid_o, count_o, data_o, parity_err_o, frame_err_o, overflow_o} !== 16'h0) begin
      errors++;
      $display("FAIL rstmid_outputs got v=%0b c=%0d d=%02h flags=%b expected all 0", valid_o,
               count_o, data_o, {parity_err_o, frame_err_o, overflow_o});
    end
    rst_i = 1'b0;
    waitCyc(5);
    sendFrame(8'h29, 1'b0);
    checks++;
    if (data_o !== 8'h29 || count_o !== 4'd1 || frame_err_o !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_next got d=%02h c=%0d fe=%0b expected 29 1 0", data_o, count_o, frame_err_o);
    end
    popOne();
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic flip;
    clearErr();
    popOne();
    checks++;
    if (count_o !== 4'd0 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL rnd_emptyread got c=%0d v=%0b expected 0 0", count_o, valid_o);
    end
    for (int it = 0; it < 14; it++) begin
      d    = 8'($urandom_range(0, 255));
      flip = ($urandom_range(0, 5) == 0);
      sendFrame(d, flip);
      if ($urandom_range(0, 2) == 0) popOne();
      checks++;
      if (count_o !== 4'(q.size()) || valid_o !== (q.size() > 0) || data_o !== headExp()) begin
        errors++;
        $display("FAIL rnd_fifo%0d got c=%0d v=%0b d=%02h expected c=%0d d=%02h", it, count_o,
                 valid_o, data_o, q.size(), headExp());
      end
      checks++;
      if ({parity_err_o, frame_err_o, overflow_o} !== {expPar, expFrm, expOvf}) begin
        errors++;
        $display("FAIL rnd_flags%0d got %b expected %b", it,
                 {parity_err_o, frame_err_o, overflow_o}, {expPar, expFrm, expOvf});
      end
    end
  endtask

  initial begin
    test_reset();
    test_two_frames();
    test_parity_err();
    test_overflow();
    test_timeout();
    test_glitch();
    test_reset_midframe();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_kb_rx.md
PS2_KB_RX -- requirements
Module: ps2_kb_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, meaning clk_i frequency in Hz.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning number of scancode entries; power of two, 2 or more.
REQ-003 SHALL have parameter FILTER_LEN, default 8, meaning kb_clk_i glitch-filter length in cycles.
REQ-004 SHALL have parameter TIMEOUT_US, default 200, meaning the mid-frame inactivity limit in microseconds.
REQ-005 clk_i  input  1  system clock; the only clock.
REQ-006 rst_i  input  1  reset, asynchronous, active-high.
REQ-007 kb_clk_i  input  1  PS/2 clock, asynchronous to clk_i.
REQ-008 kb_dat_i  input  1  PS/2 data, asynchronous to clk_i.
REQ-009 rd_i  input  1  pop the FIFO head.
REQ-010 err_clr_i  input  1  clears all sticky error flags.
REQ-011 data_o  output  8  FIFO head byte; valid while valid_o=1.
REQ-012 valid_o  output  1  FIFO not empty.
REQ-013 count_o  output  log2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-014 parity_err_o, frame_err_o, overflow_o  output  1 each  sticky error flags.

Function
REQ-015 SHALL pass kb_clk_i and kb_dat_i through 2-FF synchronizers before any use.
REQ-016 Filtered clock SHALL go 0 only after FILTER_LEN consecutive synchronized 0 samples, and SHALL go 1 only after FILTER_LEN consecutive 1 samples; otherwise it SHALL hold its value.
REQ-017 A 1->0 transition of the filtered clock is a "fall"; data SHALL be sampled from synchronized kb_dat_i in the fall cycle.
REQ-018 FSM states: IDLE, DATA, PARITY, STOP.
REQ-019 IDLE: a fall with data=0 SHALL go to DATA with bit count 0; a fall with data=1 SHALL be ignored.
REQ-020 DATA: 8 falls SHALL shift in bits LSB first, then go to PARITY.
REQ-021 PARITY: one fall SHALL latch the parity bit, then go to STOP.
REQ-022 STOP, on a fall: stop=0 SHALL set frame_err_o; stop=1 with even total ones over data+parity SHALL set parity_err_o; otherwise the byte SHALL be pushed. In all three cases the FSM SHALL return to IDLE.
REQ-023 A discarded frame SHALL never reach the FIFO.
REQ-024 When not in IDLE, a timeout counter SHALL reset on every fall.
REQ-025 When the timeout counter reaches CLK_FREQ/1000000*TIMEOUT_US cycles, frame_err_o SHALL be set and the FSM SHALL return to IDLE with the partial byte discarded.
REQ-026 The FIFO SHALL be first-word-fall-through: valid_o, data_o and count_o SHALL update on the clk_i edge after the stop-bit fall cycle.
REQ-027 rd_i while empty SHALL be ignored.
REQ-028 A push while full without rd_i SHALL drop the new byte and set overflow_o.
REQ-029 A push and rd_i in the same cycle while full SHALL pop the head and accept the new byte, count unchanged, no overflow.
REQ-030 A push and rd_i in the same cycle while empty SHALL leave the FIFO empty and not lose the byte: it SHALL be written and appear next cycle.
REQ-031 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-032 err_clr_i SHALL clear all sticky flags on the next edge; an error event in the same cycle SHALL win and set its flag.

Reset
REQ-033 rst_i SHALL asynchronously force: FSM to IDLE; bit and timeout counters to 0; FIFO empty (valid_o=0, count_o=0, data_o=0); all error flags to 0; synchronizers and filter to 1 (idle-high line).
REQ-034 rst_i asserted mid-frame SHALL discard the partial frame; reception SHALL resume with the next start bit after release.

Structure
REQ-035 A shared ps2 definitions header SHALL hold the FSM state encodings, the frame bit count (11), and the default TIMEOUT_US.
REQ-036 The FIFO SHALL be a separate sub-module ps2_rx_fifo (DEPTH, WIDTH=8).
REQ-037 The synchronizer, filter, FSM and timeout logic SHALL stay in ps2_kb_rx.

Verification
REQ-038 Frames 0x1C (parity 0) then 0xF0 (parity 1) at 12.5 kHz -> count_o=2, data_o=0x1C, after rd_i data_o=0xF0, no flags set.
REQ-039 Frame 0x1C with parity bit 1 -> parity_err_o=1, valid_o stays 0; err_clr_i -> parity_err_o=0.
REQ-040 Nine valid frames 0x01..0x09 with no reads -> count_o=8, overflow_o=1; pops return 0x01..0x08.
REQ-041 kb_clk_i stopped after 4 data bits for 250 us -> frame_err_o=1, FSM IDLE; next frame 0x5A received intact.
REQ-042 A 3-cycle low glitch on kb_clk_i in IDLE -> no state change, no push.
REQ-043 rst_i pulsed after 5 bits of a frame -> all outputs 0; subsequent frame 0x29 received with count_o=1.
